// File: rtl/reset_sequencer_if.sv
// Reset sequencer side-band bundle: software request in, per-channel resets and done flag out.
// Latency: n/a (wires only). Backpressure: none.
// The sequencer drives rst_out/rst_done; its controller drives sw_rst_req.
interface reset_sequencer_if #(
    parameter int NUM_CH = 3
);
    logic              sw_rst_req;
    logic [NUM_CH-1:0] rst_out;
    logic              rst_done;

    modport master (output sw_rst_req, input rst_out, rst_done);
    modport slave  (input sw_rst_req, output rst_out, rst_done);
endinterface

// File: rtl/reset_sequencer.sv
// Reset sequencer: async assert, synchronised release, hold, then staggered per-channel deassert.
// Latency: channel k releases SYNC_STAGES+HOLD_CYCLES+k*STEP_CYCLES edges after reset release.
// Backpressure: none; sw_rst_req is a level, re-running hold/release while sampled high.
module reset_sequencer #(
    parameter int                NUM_CH      = 3,
    parameter int                SYNC_STAGES = 2,
    parameter int                HOLD_CYCLES = 4,
    parameter int                STEP_CYCLES = 3,
    parameter logic [NUM_CH-1:0] ACTIVE_VAL  = {NUM_CH{1'b1}}
) (
    input  logic             clk_in,
    input  logic             rst_in_n,
    reset_sequencer_if.slave rst_if
);
    localparam int MAX_CYC = (HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int IDX_W   = $clog2(NUM_CH) + 1;
    localparam int CHAIN_W = SYNC_STAGES - 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CHAIN_W-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [NUM_CH-1:0] rst_out_q, rst_out_d;
    logic              done_q, done_d;

    always_comb begin
        sync_d    = CHAIN_W'({sync_q, 1'b1});
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        rst_out_d = rst_out_q;
        done_d    = done_q;

        case (state_q)
            // The state flop itself is the final synchroniser stage, so HOLD
            // is entered on edge SYNC_STAGES with the counter at zero.
            ASSERT: begin
                if (sync_q[CHAIN_W-1]) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d        = '0;
                    rst_out_d[0] = ~ACTIVE_VAL[0];
                    idx_d        = IDX_W'(1);
                    if (NUM_CH == 1) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RELEASE: begin
                if (cnt_q == STEP_LAST) begin
                    cnt_d = '0;
                    for (int k = 0; k < NUM_CH; k++) begin
                        if (IDX_W'(k) == idx_q) begin
                            rst_out_d[k] = ~ACTIVE_VAL[k];
                        end
                    end
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IDX_LAST) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = ASSERT;
            end
        endcase

        // Software request overrides any release due on this same edge.
        if (rst_if.sw_rst_req && (state_q != ASSERT)) begin
            state_d   = HOLD;
            cnt_d     = '0;
            idx_d     = '0;
            rst_out_d = ACTIVE_VAL;
            done_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state_q   <= ASSERT;
            sync_q    <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            rst_out_q <= ACTIVE_VAL;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            rst_out_q <= rst_out_d;
            done_q    <= done_d;
        end
    end

    assign rst_if.rst_out  = rst_out_q;
    assign rst_if.rst_done = done_q;
endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised reset generator for a single clock domain. Accepts an asynchronous active-low reset and asserts all outputs immediately. Synchronises reset deassertion, holds reset for a programmable minimum time, then releases NUM_CH reset outputs one after another in a fixed order with a programmable gap between channels. A synchronous software reset request re-runs the hold-and-release sequence without a hard reset. Sits next to each clock domain's root and feeds the per-subsystem resets in that domain.

## Interface
- NUM_CH, 3: number of reset output channels, 1..32.
- SYNC_STAGES, 2: synchroniser depth for rst_in_n deassertion, ≥2.
- HOLD_CYCLES, 4: minimum hold, in clk_in cycles, between synchroniser release (or end of software request) and channel 0 release, ≥1.
- STEP_CYCLES, 3: clk_in cycles between consecutive channel releases, ≥1.
- ACTIVE_VAL, {NUM_CH{1'b1}}: per-channel asserted level of rst_out. Bit k=1 means channel k is active-high.
- clk_in, input, 1: the single clock.
- rst_in_n, input, 1: reset, asynchronous and active-low. Asserts asynchronously; deassertion is synchronised internally.
- sw_rst_req, input, 1: synchronous, active-high, level-sensitive software reset request.
- rst_out, output, NUM_CH: per-channel resets. Channel k is asserted when rst_out[k]==ACTIVE_VAL[k].
- rst_done, output, 1: high when every channel is released.

## Operation
- States: ASSERT, HOLD, RELEASE, DONE.
- While rst_in_n is low:
  - rst_out = ACTIVE_VAL and rst_done = 0, asynchronously, with no clock required.
  - The synchroniser chain is cleared, the counter and channel index are cleared, and the FSM is in ASSERT.
- ASSERT:
  - Ones shift through a SYNC_STAGES-deep chain.
  - When the chain output is high, go to HOLD with the counter at 0.
- HOLD:
  - The counter increments each cycle.
  - When the counter reaches HOLD_CYCLES, channel 0 is released, the index is set to 1, and the FSM goes to RELEASE, or to DONE if NUM_CH==1.
- RELEASE:
  - The counter restarts for each channel.
  - After STEP_CYCLES cycles, channel index k is released and the index increments.
  - Release of channel NUM_CH-1 moves the FSM to DONE.
- DONE: rst_out = ~ACTIVE_VAL and rst_done = 1. The FSM stays in DONE.
- Released channels stay released until a new reset event; release is monotonic within one sequence.
- sw_rst_req, in HOLD, RELEASE or DONE:
  - At any edge where it is sampled high, all rst_out bits are re-asserted to ACTIVE_VAL and rst_done goes to 0, both registered.
  - The FSM goes to HOLD with the counter at 0.
  - While the request stays high, the counter is held at 0.
- sw_rst_req in ASSERT is ignored, because all outputs are already asserted.
- rst_in_n low mid-sequence at any state aborts the sequence immediately to the reset condition above.
- Counter width is clog2(max(HOLD_CYCLES,STEP_CYCLES)+1). The counter never wraps: it is cleared on every transition.
- Channel index width is clog2(NUM_CH)+1.
- All outputs come directly from flops; no combinational path from any input to any output.
- Flops clear or preset asynchronously on rst_in_n low; preset or clear per bit is chosen from ACTIVE_VAL.

## Timing
- Edge 1 is the first rising clk_in edge at which rst_in_n is sampled high.
- Synchroniser output goes high after edge SYNC_STAGES.
- Channel k deasserts at edge SYNC_STAGES+HOLD_CYCLES+k·STEP_CYCLES.
- rst_done rises at the same edge as channel NUM_CH-1 deasserts.
- Software request, with M = last edge at which sw_rst_req is sampled high:
  - Outputs re-assert at the first edge where the request is sampled high.
  - Channel k deasserts at edge M+HOLD_CYCLES+k·STEP_CYCLES.
- sw_rst_req high on the same edge that a channel would release: the request wins, and no channel is released on that edge.
- rst_in_n deasserting close to a clk_in edge may add one cycle of latency (metastability window); the bench treats ±1 cycle as legal for first release only.

## Test plan
Default parameters for scenarios 1–4: NUM_CH=3, SYNC_STAGES=2, HOLD_CYCLES=4, STEP_CYCLES=3, ACTIVE_VAL=3'b101.

1. Power-on with defaults -> rst_out=3'b101 while rst_in_n is low. Release at edge 6 gives 3'b100, edge 9 gives 3'b110, edge 12 gives 3'b010, and rst_done=1 at edge 12.
2. Drop rst_in_n between clock edges after edge 7 -> rst_out returns to 3'b101 and rst_done=0 without a clock edge. The sequence restarts with the same edge numbering.
3. sw_rst_req high for 1 cycle at edge 20 in DONE -> 3'b101 at edge 20, then releases at edges 24, 27 and 30.
4. sw_rst_req held high for edges 20–25 -> releases at edges 29, 32 and 35. rst_done=0 throughout edges 20–34.
5. NUM_CH=1, HOLD_CYCLES=1 -> single channel released at edge 3, with rst_done at edge 3.
